// File: rtl/tribus_pkg.sv
// Shared types and defaults for the tri-state bus arbiter.
// Imported by the arbiter top and its round-robin picker.
package tribus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } tribus_state_e;

    localparam int TURN_GAP_DEF = 2;
    localparam int MAX_HOLD_DEF = 8;

endpackage

// File: rtl/tribus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit at or above ptr,
// wrapping modulo N, returned one-hot with a valid flag.
module rr_pick
    import tribus_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req_v,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          valid
);

    // Scan N slots starting at ptr; the first eligible one wins.
    always_comb begin
        int j;
        j     = 0;
        gnt   = '0;
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr) + i) % N;
            if (!valid && req_v[j]) begin
                gnt[j] = 1'b1;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tribus_arbiter.sv
// Round-robin owner/enable sequencer for a notif1-style tri-state bus,
// with undriven turn-off gaps between owners and a hold timeout.
module tribus_arbiter
    import tribus_pkg::*;
#(
    parameter int N        = 4,
    parameter int TURN_GAP = TURN_GAP_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic [N-1:0] drv_en,
    output logic         busy,
    output logic         timeout
);

    localparam int PW = $clog2(N);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam int GW = $clog2(TURN_GAP + 1);

    tribus_state_e state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [N-1:0]  mask_q, mask_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] owner_q, owner_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic          busy_q, busy_d;
    logic          timeout_q, timeout_d;

    logic [N-1:0]  pick_gnt;
    logic          pick_valid;
    logic [PW-1:0] pick_idx;
    logic [PW-1:0] owner_next;

    rr_pick #(
        .N (N),
        .PW(PW)
    ) u_pick (
        .req_v(req & ~mask_q),
        .ptr  (ptr_q),
        .gnt  (pick_gnt),
        .valid(pick_valid)
    );

    // Binary index of the picked winner and the pointer slot after the owner.
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (pick_gnt[i]) begin
                pick_idx = PW'(i);
            end
        end
        owner_next = (owner_q == PW'(N - 1)) ? '0 : owner_q + PW'(1);
    end

    // Next-state and registered-output logic for IDLE/DRIVE/GAP.
    always_comb begin
        state_d    = state_q;
        grant_d    = '0;
        mask_d     = mask_q & req;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        hold_cnt_d = hold_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        timeout_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d    = ST_DRIVE;
                    grant_d    = pick_gnt;
                    owner_d    = pick_idx;
                    hold_cnt_d = '0;
                end
            end
            ST_DRIVE: begin
                if (!req[owner_q] || hold_cnt_q == HW'(MAX_HOLD - 1)) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = '0;
                    ptr_d     = owner_next;
                    if (req[owner_q]) begin
                        timeout_d       = 1'b1;
                        mask_d[owner_q] = 1'b1;
                    end
                end else begin
                    grant_d = grant_q;
                    if (hold_cnt_q != HW'(MAX_HOLD)) begin
                        hold_cnt_d = hold_cnt_q + HW'(1);
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GW'(TURN_GAP - 1)) begin
                    if (pick_valid) begin
                        state_d    = ST_DRIVE;
                        grant_d    = pick_gnt;
                        owner_d    = pick_idx;
                        hold_cnt_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset drops every enable at once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            mask_q     <= '0;
            ptr_q      <= '0;
            owner_q    <= '0;
            hold_cnt_q <= '0;
            gap_cnt_q  <= '0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            mask_q     <= mask_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            hold_cnt_q <= hold_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
        end
    end

    assign grant   = grant_q;
    assign drv_en  = grant_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_tribus_arbiter.sv
// Randomized and directed bench for tribus_arbiter against a
// cycle-level behavioural model of owner, gap and mask rules.
module tb_tribus_arbiter;

    localparam int N        = 4;
    localparam int TURN_GAP = 2;
    localparam int MAX_HOLD = 8;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] grant;
    logic [N-1:0] drv_en;
    logic         busy;
    logic         timeout;

    int n_checks;
    int n_fail;

    // Reference model state
    int           m_owner;
    int           m_driven;
    int           m_gap;
    int           m_ptr;
    logic [N-1:0] m_mask;
    logic [N-1:0] m_grant;
    logic         m_busy;
    logic         m_tmo;

    tribus_arbiter #(
        .N       (N),
        .TURN_GAP(TURN_GAP),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .grant  (grant),
        .drv_en (drv_en),
        .busy   (busy),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_arb(input logic [N-1:0] r, input logic [N-1:0] om);
        bit found;
        int c;
        found = 0;
        for (int k = 0; k < N; k++) begin
            c = (m_ptr + k) % N;
            if (!found && r[c] && !om[c]) begin
                found    = 1;
                m_owner  = c;
                m_driven = 0;
            end
        end
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic rs);
        logic [N-1:0] om;
        om = m_mask;
        if (!rs) begin
            m_owner  = -1;
            m_driven = 0;
            m_gap    = 0;
            m_ptr    = 0;
            m_mask   = '0;
            m_tmo    = 1'b0;
        end else begin
            m_tmo  = 1'b0;
            m_mask = m_mask & r;
            if (m_owner >= 0) begin
                m_driven++;
                if (!r[m_owner] || m_driven == MAX_HOLD) begin
                    if (r[m_owner]) begin
                        m_tmo          = 1'b1;
                        m_mask[m_owner] = 1'b1;
                    end
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = -1;
                    m_gap   = TURN_GAP;
                end
            end else if (m_gap > 0) begin
                m_gap--;
                if (m_gap == 0) model_arb(r, om);
            end else begin
                model_arb(r, om);
            end
        end
        m_grant = '0;
        if (m_owner >= 0) m_grant[m_owner] = 1'b1;
        m_busy = (m_owner >= 0) || (m_gap > 0);
    endtask

    // One clock: drive at negedge, model at posedge, sample #1 later.
    task automatic cycle(input logic [N-1:0] r, input logic rs);
        req   = r;
        rst_n = rs;
        @(posedge clk);
        model_step(r, rs);
        #1;
        check("grant", 32'(grant), 32'(m_grant));
        check("drv_en", 32'(drv_en), 32'(m_grant));
        check("busy", 32'(busy), 32'(m_busy));
        check("timeout", 32'(timeout), 32'(m_tmo));
        check("onehot0", 32'($onehot0(drv_en)), 32'd1);
        @(negedge clk);
    endtask

    function automatic int idx_of(input logic [N-1:0] g);
        int k;
        k = -1;
        for (int i = 0; i < N; i++) if (g[i]) k = i;
        return k;
    endfunction

    initial begin
        int           gcnt;
        int           tcnt;
        int           zrun;
        int           nlog;
        int           glog[5];
        int           exp_order[5];
        logic [N-1:0] prev;
        logic [N-1:0] r;
        logic [N-1:0] base;
        logic         rs;
        bit           hit;

        n_checks = 0;
        n_fail   = 0;
        m_owner  = -1;
        m_driven = 0;
        m_gap    = 0;
        m_ptr    = 0;
        m_mask   = '0;
        m_grant  = '0;
        m_busy   = 1'b0;
        m_tmo    = 1'b0;
        req      = '0;
        rst_n    = 1'b0;
        exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 2;
        exp_order[3] = 3; exp_order[4] = 0;

        @(negedge clk);
        cycle('0, 1'b0);
        cycle('0, 1'b0);
        check("rst_grant", 32'(grant), 32'd0);

        // Single requester for three cycles
        gcnt = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(4'b0001, 1'b1);
            if (grant == 4'b0001) gcnt++;
        end
        cycle(4'b0000, 1'b1);
        check("single_drop", 32'(grant), 32'd0);
        check("single_gap1", 32'(busy), 32'd1);
        cycle(4'b0000, 1'b1);
        check("single_gap2", 32'(busy), 32'd1);
        cycle(4'b0000, 1'b1);
        check("single_idle", 32'(busy), 32'd0);
        check("single_len", 32'(gcnt), 32'd3);

        // All requesting, each owner drops after two cycles
        cycle('0, 1'b0);
        nlog = 0;
        zrun = 0;
        prev = '0;
        for (int c = 0; c < 60 && nlog < 5; c++) begin
            r = 4'b1111;
            if (m_owner >= 0 && m_driven == 1) r[m_owner] = 1'b0;
            cycle(r, 1'b1);
            if (grant != 0 && prev == 0) begin
                if (nlog > 0) check("rr_gap", 32'(zrun), 32'd2);
                glog[nlog] = idx_of(grant);
                nlog++;
                zrun = 0;
            end else if (grant == 0) begin
                zrun++;
            end
            prev = grant;
        end
        check("rr_count", 32'(nlog), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < nlog) check("rr_order", 32'(glog[i]), 32'(exp_order[i]));
        end
        cycle('0, 1'b1);
        cycle('0, 1'b1);
        cycle('0, 1'b1);

        // Timeout on a lone holder
        gcnt = 0;
        tcnt = 0;
        for (int i = 0; i < 14; i++) begin
            cycle(4'b0100, 1'b1);
            if (grant == 4'b0100) gcnt++;
            if (timeout) tcnt++;
        end
        check("tmo_len", 32'(gcnt), 32'(MAX_HOLD));
        check("tmo_pulses", 32'(tcnt), 32'd1);
        cycle(4'b0000, 1'b1);
        cycle(4'b0100, 1'b1);
        check("tmo_regrant", 32'(grant), 32'b0100);
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b1);

        // Timeout with a competitor
        cycle('0, 1'b0);
        for (int i = 0; i < MAX_HOLD + TURN_GAP + 1; i++) begin
            cycle(4'b0101, 1'b1);
        end
        check("comp_second", 32'(grant), 32'b0100);
        for (int i = 0; i < MAX_HOLD + TURN_GAP + 3; i++) begin
            cycle(4'b0101, 1'b1);
        end
        check("comp_masked", 32'(grant), 32'd0);
        cycle(4'b0000, 1'b1);

        // Request rising in the first gap cycle
        cycle('0, 1'b0);
        cycle(4'b0001, 1'b1);
        cycle(4'b0001, 1'b1);
        cycle(4'b0000, 1'b1);
        cycle(4'b1000, 1'b1);
        check("gapreq_wait", 32'(grant), 32'd0);
        cycle(4'b1000, 1'b1);
        check("gapreq_grant", 32'(grant), 32'b1000);
        cycle(4'b0000, 1'b1);

        // Reset while bit 1 drives
        cycle('0, 1'b0);
        hit = 0;
        for (int c = 0; c < 40 && !hit; c++) begin
            r = 4'b1111;
            if (m_owner == 0 && m_driven == 1) r[0] = 1'b0;
            cycle(r, 1'b1);
            if (grant == 4'b0010) hit = 1;
        end
        check("rst_mid_reach", 32'(hit), 32'd1);
        cycle(4'b1111, 1'b0);
        check("rst_mid_grant", 32'(grant), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        cycle(4'b1111, 1'b1);
        check("rst_mid_next", 32'(grant), 32'b0001);

        // Random traffic
        base = '0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) base = N'($urandom);
            r = base;
            if ($urandom_range(0, 3) == 0)
                r = r ^ (N'(1) << $urandom_range(0, N - 1));
            rs = ($urandom_range(0, 299) != 0);
            cycle(r, rs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tribus_arbiter.md
# tribus_arbiter

Round-robin arbiter and enable sequencer for a shared tri-state bus built from `notif1`-style drivers, one driver per requester. It grants the bus to one requester at a time and drives that requester's driver-enable, which connects to the driver's control input. Between owners it inserts a programmable number of undriven turn-off cycles, so the turn-off of one driver never overlaps the turn-on of the next. A hold timeout stops any single requester from monopolising the bus.

## Interface
- `N`, 4: number of requesters (2..16).
- `TURN_GAP`, 2: cycles the bus stays undriven between owners (≥1).
- `MAX_HOLD`, 8: maximum consecutive cycles one owner may drive (≥1).
- `clk`  in  1  sole clock; all state changes on rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `req`  in  N  per-requester bus request, level; held high while the bus is wanted.
- `grant`  out  N  one-hot current owner, or all zero.
- `drv_en`  out  N  driver enables, wired to the tri-state driver control inputs; always equal to `grant`.
- `busy`  out  1  high in DRIVE or GAP.
- `timeout`  out  1  one-cycle pulse when an owner is forcibly released.

## Operation
- States: IDLE, DRIVE, GAP. All outputs are registered.
- **IDLE**
  - `grant`=0.
  - On an edge where any unmasked `req` is high, pick the winner by round-robin, scanning from `ptr` upward and wrapping mod N.
  - Go to DRIVE with `grant`=`drv_en`=onehot(winner) and `hold_cnt`=0.
- **DRIVE**
  - `hold_cnt` increments each cycle, saturating.
  - Release when `req[owner]`=0, or when `hold_cnt`=MAX_HOLD-1, whichever comes first.
  - On release, the same edge clears `grant`, loads `ptr`=(owner+1) mod N, clears `gap_cnt`, and enters GAP.
  - On a forced release (timeout while `req[owner]` is still 1): pulse `timeout` and set `mask[owner]`.
- **GAP**
  - `grant`=0 for exactly TURN_GAP cycles.
  - On the edge ending the last gap cycle, arbitrate exactly as in IDLE: go straight to DRIVE if any unmasked request is pending, otherwise go to IDLE.
- **Mask**
  - `mask[i]` clears on any edge where `req[i]`=0.
  - A masked requester cannot win arbitration.
  - A timed-out requester must drop `req` for at least one cycle before it can be granted again.
- **Counter widths**
  - `hold_cnt`: $clog2(MAX_HOLD+1) bits.
  - `gap_cnt`: $clog2(TURN_GAP+1) bits.
  - `ptr`: $clog2(N) bits; wraps N-1→0.
- **Reset values:** state=IDLE, `grant`=`drv_en`=0, `busy`=0, `timeout`=0, `ptr`=0, `mask`=0, all counters 0.
- **Reset mid-DRIVE:** bus enables drop on that edge with no GAP; arbitration restarts from `ptr`=0.

## Timing
- Grant latency from IDLE: `req` high before edge k → `grant` high after edge k.
- An owner with `req` continuously high drives for exactly MAX_HOLD cycles.
- Drop of `req[owner]` sampled at edge k → `drv_en` low after edge k.
- Between two owners, exactly TURN_GAP cycles have `drv_en`=0.
- A `req` rising during GAP is honoured at the end of that gap; it does not extend the gap.
- Simultaneous release and new requests: the released owner ranks lowest in the next arbitration because `ptr` has moved past it.
- `req` from a non-owner has no effect on the current DRIVE.
- At most one `drv_en` bit is high in any cycle. This is an invariant to assert.

## Structure
- Shared package `tribus_pkg` holds:
  - the state enum (IDLE, DRIVE, GAP);
  - the default values of `TURN_GAP` and `MAX_HOLD`.
- One natural sub-module, `rr_pick`: a combinational round-robin picker.
  - Inputs: `req & ~mask`, `ptr`.
  - Outputs: one-hot winner and a valid flag.

## Test plan
All scenarios use N=4, TURN_GAP=2, MAX_HOLD=8.
- **Single requester:** `req`=0001 for 3 cycles, then 0000 → `grant`=0001 for 3 cycles from the edge after the request; then `busy` high for 2 GAP cycles, then IDLE.
- **All requesting, short holds:** `req`=1111; each owner drops its `req` 2 cycles after its grant, then re-raises it → grant order 0,1,2,3,0; exactly 2 zero-`drv_en` cycles between owners.
- **Timeout:** `req`=0100 held high → `grant`=0100 for exactly 8 cycles, `timeout` pulses once, GAP; no re-grant until `req[2]` drops for at least one cycle.
- **Timeout with a competitor:** `req`=0101 held high → after bit 0 times out, bit 2 is granted after the 2 gap cycles; bit 0 stays masked while its `req` remains high.
- **Request during GAP:** `req[3]` rises in gap cycle 1 → `grant`=1000 immediately after the 2nd gap cycle, no extra delay.
- **Reset mid-DRIVE:** `rst_n`=0 for one edge while `grant`=0010 → all outputs 0 after that edge; with `req`=1111, the next grant is 0001.
